// File: rtl/scope_capture.sv
// Multi-channel triggered capture buffer with pre-trigger history and decimation.
// Optional forced trigger after a long WAIT is enabled with `define SCOPE_CAPTURE_AUTO_TRIG_EN.
module scope_capture #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DW    = 12,
    parameter int unsigned DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    input  logic [NCH*DW-1:0]        sample_data,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [2:0]               address,
    input  logic [15:0]              writedata,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [NCH*DW-1:0]        rd_data,
    output logic                     armed,
    output logic                     triggered,
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
    output logic                     auto_trig,
`endif
    output logic                     done
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StPre, StWait, StPost, StDone} state_t;

    state_t              r_state, w_state_nxt;
    logic [DW-1:0]       r_level;
    logic [AW-1:0]       r_pretrig, r_pre;
    logic [15:0]         r_decim, r_dec_cnt;
    logic                r_edge;
    logic [2:0]          r_trig_ch;
    logic [AW-1:0]       r_wptr, r_tptr, r_cnt;
    logic [NCH*DW-1:0]   r_prev;
    logic                r_prev_vld;
    logic                r_armed, r_trig, r_done;
    logic [NCH*DW-1:0]   r_rd_data;
    logic [NCH*DW-1:0]   r_mem [DEPTH];

    logic                w_wr, w_arm, w_active, w_dec_hit, w_post_full, w_accept;
    logic                w_edge_hit, w_force, w_trig;
    logic [AW-1:0]       w_post_len, w_pre_wr, w_rd_phys;
    logic [DW-1:0]       w_cur, w_prv;
    logic [2:0]          w_ch_mod;

`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
    logic [11:0]         r_wait_cnt;
    logic                r_auto;
    assign w_force   = (r_wait_cnt == 12'hFFF);
    assign auto_trig = r_auto;
`else
    assign w_force   = 1'b0;
`endif

    always_comb begin
        w_wr        = chipselect && write;
        w_arm       = w_wr && (address == 3'd0) && writedata[0];
        w_active    = (r_state == StPre) || (r_state == StWait) || (r_state == StPost);
        w_dec_hit   = (r_dec_cnt >= r_decim);
        w_post_len  = AW'(DEPTH - 1) - r_pre;
        // A zero-length post window must not overwrite the oldest pre-trigger sample.
        w_post_full = (r_state == StPost) && (r_cnt == w_post_len);
        w_accept    = sample_valid && w_active && w_dec_hit && !w_arm && !w_post_full;
        w_cur       = sample_data[r_trig_ch*DW +: DW];
        w_prv       = r_prev[r_trig_ch*DW +: DW];
        w_edge_hit  = r_prev_vld && (r_edge ? (w_prv > r_level && w_cur <= r_level)
                                            : (w_prv < r_level && w_cur >= r_level));
        w_trig      = (r_state == StWait) && w_accept && (w_edge_hit || w_force);
        w_pre_wr    = (32'(writedata) >= DEPTH) ? AW'(DEPTH - 1) : AW'(writedata);
        w_ch_mod    = 3'(32'(writedata[4:2]) % NCH);
        w_rd_phys   = r_tptr - r_pre + rd_addr;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_arm) begin
            w_state_nxt = StPre;
        end else begin
            case (r_state)
                StPre: begin
                    if (r_pre == '0) w_state_nxt = StWait;
                    else if (w_accept && AW'(r_cnt + 1'b1) == r_pre) w_state_nxt = StWait;
                end
                StWait: if (w_trig) w_state_nxt = StPost;
                StPost: begin
                    if (w_post_full || (w_accept && AW'(r_cnt + 1'b1) == w_post_len))
                        w_state_nxt = StDone;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_level    <= '0;
            r_pretrig  <= '0;
            r_pre      <= '0;
            r_decim    <= '0;
            r_dec_cnt  <= '0;
            r_edge     <= 1'b0;
            r_trig_ch  <= '0;
            r_wptr     <= '0;
            r_tptr     <= '0;
            r_cnt      <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_armed    <= 1'b0;
            r_trig     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_data  <= '0;
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
            r_wait_cnt <= '0;
            r_auto     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_armed   <= (w_state_nxt == StPre) || (w_state_nxt == StWait) ||
                         (w_state_nxt == StPost);
            r_trig    <= (w_state_nxt == StPost) || (w_state_nxt == StDone);
            r_done    <= (w_state_nxt == StDone);
            r_rd_data <= r_mem[w_rd_phys];
            if (w_wr) begin
                case (address)
                    3'd0: begin
                        r_edge    <= writedata[1];
                        r_trig_ch <= w_ch_mod;
                    end
                    3'd1: r_level   <= DW'(writedata);
                    3'd2: r_pretrig <= w_pre_wr;
                    3'd3: r_decim   <= writedata;
                    default: ;
                endcase
            end
            if (w_arm) begin
                r_pre      <= r_pretrig;
                r_wptr     <= '0;
                r_cnt      <= '0;
                r_dec_cnt  <= '0;
                r_prev_vld <= 1'b0;
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
                r_wait_cnt <= '0;
                r_auto     <= 1'b0;
`endif
            end else begin
                if (sample_valid && w_active) r_dec_cnt <= w_dec_hit ? '0 : r_dec_cnt + 16'd1;
                if (w_accept) begin
                    r_wptr     <= r_wptr + 1'b1;
                    r_prev     <= sample_data;
                    r_prev_vld <= 1'b1;
                    if (w_trig) begin
                        r_tptr <= r_wptr;
                        r_cnt  <= '0;
                    end else if (r_state != StWait) begin
                        r_cnt  <= r_cnt + 1'b1;
                    end
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
                    if (r_state == StWait) r_wait_cnt <= r_wait_cnt + 12'd1;
                    if (w_trig && !w_edge_hit) r_auto <= 1'b1;
`endif
                end
            end
        end
    end

    // Sample storage is deliberately unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wptr] <= sample_data;
    end

    assign rd_data   = r_rd_data;
    assign armed     = r_armed;
    assign triggered = r_trig;
    assign done      = r_done;

endmodule

// File: tb/tb_scope_capture.sv
// Randomized bench for scope_capture; the reference model tracks the list of
// accepted samples and derives trigger index, flags and buffer contents from it.
module tb_scope_capture;
    localparam int NCH = 2, DW = 12, DEPTH = 512, AW = 9;

    logic              clk = 1'b0, reset_n = 1'b0, sample_valid = 1'b0;
    logic [NCH*DW-1:0] sample_data = '0;
    logic              chipselect = 1'b0, write = 1'b0;
    logic [2:0]        address = '0;
    logic [15:0]       writedata = '0;
    logic [AW-1:0]     rd_addr = '0;
    logic [NCH*DW-1:0] rd_data;
    logic              armed, triggered, done;
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
    logic              auto_trig;
`endif

    scope_capture #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_data(sample_data), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .rd_addr(rd_addr),
        .rd_data(rd_data), .armed(armed), .triggered(triggered),
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
        .auto_trig(auto_trig),
`endif
        .done(done)
    );

    always #10 clk = ~clk;

    int n_total = 0, n_bad = 0;

    // Reference model state
    logic [NCH*DW-1:0] acc_q[$];
    int m_trig, m_P, m_D, m_ch, m_level, n_valid;
    bit m_done, m_edge, m_auto;

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int field(input logic [NCH*DW-1:0] s, input int ch);
        return int'(s[ch*DW +: DW]);
    endfunction

    function automatic bit edge_hit(input int prv, input int cur);
        if (m_edge) return (prv > m_level) && (cur <= m_level);
        return (prv < m_level) && (cur >= m_level);
    endfunction

    function automatic logic [NCH*DW-1:0] make_sample(input int kind, input int n);
        logic [NCH*DW-1:0] s;
        int v;
        for (int k = 0; k < NCH; k++) s[k*DW +: DW] = DW'($urandom_range(0, 4095));
        case (kind)
            0:       v = n % 4096;
            1:       v = 4095 - (n % 4096);
            3:       v = (n < 30) ? 100 : (n < 60) ? 3000 : (n < 1200) ? 100 : 3000;
            4:       v = 0;
            default: v = int'($urandom_range(0, 4095));
        endcase
        s[m_ch*DW +: DW] = DW'(v);
        return s;
    endfunction

    task automatic reg_write(input int a, input int d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 3'(a); writedata = 16'(d);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic arm_cfg(input int p, input int d, input bit e, input int ch, input int lvl);
        reg_write(1, lvl);
        reg_write(2, p);
        reg_write(3, d);
        reg_write(0, (ch << 2) | (int'(e) << 1) | 1);
        m_P = (p >= DEPTH) ? DEPTH - 1 : p;
        m_D = d; m_edge = e; m_ch = ch % NCH; m_level = lvl;
        acc_q.delete(); m_trig = -1; m_done = 0; m_auto = 0; n_valid = 0;
        check_eq("arm_armed", armed, 1);
        check_eq("arm_triggered", triggered, 0);
        check_eq("arm_done", done, 0);
    endtask

    task automatic push(input logic [NCH*DW-1:0] s);
        int i;
        bit forced;
        @(negedge clk);
        sample_valid = 1'b1; sample_data = s;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        n_valid++;
        if (!m_done && (n_valid % (m_D + 1)) == 0) begin
            i = acc_q.size();
            acc_q.push_back(s);
            forced = 0;
`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
            forced = (i >= m_P) && (i - m_P == 4095);
`endif
            if (m_trig < 0 && i >= m_P && i >= 1) begin
                if (edge_hit(field(acc_q[i-1], m_ch), field(s, m_ch))) m_trig = i;
                else if (forced) begin
                    m_trig = i; m_auto = 1;
                end
            end
            if (m_trig >= 0 && acc_q.size() == m_trig + DEPTH - m_P) m_done = 1;
        end
        check_eq("armed", armed, !m_done);
        check_eq("triggered", triggered, m_trig >= 0);
        check_eq("done", done, m_done);
    endtask

    task automatic run(input int kind, input int abort_at);
        int pushes = 0;
        while (!m_done && pushes < 6000 && !(abort_at > 0 && acc_q.size() >= abort_at)) begin
            push(make_sample(kind, n_valid));
            pushes++;
        end
        if (abort_at == 0) check_eq("done_within_limit", done, 1);
    endtask

    task automatic read_at(input int r, output logic [NCH*DW-1:0] d);
        @(negedge clk);
        rd_addr = AW'(r);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic verify_buffer();
        logic [NCH*DW-1:0] d;
        // Samples after completion must not disturb the buffer.
        for (int k = 0; k < 3; k++) push(make_sample(2, n_valid));
        if (m_done) begin
            for (int r = 0; r < DEPTH; r++) begin
                read_at(r, d);
                check_eq("rd_data", d, acc_q[m_trig - m_P + r]);
            end
        end
    endtask

    initial begin
        logic [NCH*DW-1:0] d0, d1;
        m_ch = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_armed", armed, 0);
        check_eq("rst_triggered", triggered, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_data", rd_data, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle_armed", armed, 0);

        // Rising ramp on ch0
        arm_cfg(100, 0, 0, 0, 2048);
        run(0, 0);
        verify_buffer();
        read_at(100, d0); check_eq("ramp_rd100", field(d0, 0), 2048);
        read_at(99, d0);  check_eq("ramp_rd99", field(d0, 0), 2047);

        // Falling ramp on ch1
        arm_cfg(100, 0, 1, 1, 2048);
        run(1, 0);
        verify_buffer();
        read_at(100, d0); check_eq("fall_trig_ch1", field(d0, 1), 2048);

        // Decimation by 4
        arm_cfg(50, 3, 0, 0, 1000);
        run(0, 0);
        verify_buffer();
        read_at(10, d0); read_at(11, d1);
        check_eq("decim_step", field(d1, 0) - field(d0, 0), 4);

        // Edge during PRE ignored, later edge after a long wrapping WAIT
        arm_cfg(100, 0, 0, 0, 2048);
        run(3, 0);
        verify_buffer();
        read_at(100, d0); check_eq("pre_edge_trig", field(d0, 0), 3000);
        read_at(99, d0);  check_eq("pre_edge_prev", field(d0, 0), 100);

        // Random captures including PRETRIG boundaries and clamp
        for (int t = 0; t < 5; t++) begin
            int p;
            p = (t == 0) ? 0 : (t == 1) ? 600 : (t == 2) ? 511 : int'($urandom_range(1, 400));
            arm_cfg(p, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), int'($urandom_range(100, 4000)));
            run(2, 0);
            verify_buffer();
        end

        // Re-arm during POST
        arm_cfg(100, 0, 0, 0, 2048);
        run(0, 2100);
        check_eq("post_triggered", triggered, 1);
        arm_cfg(100, 0, 0, 0, 2048);
        run(0, 0);
        verify_buffer();

        // Asynchronous reset during POST
        arm_cfg(100, 0, 0, 0, 2048);
        run(0, 2100);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_eq("arst_armed", armed, 0);
        check_eq("arst_triggered", triggered, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_rd_data", rd_data, 0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef SCOPE_CAPTURE_AUTO_TRIG_EN
        arm_cfg(100, 0, 0, 0, 2048);
        run(4, 0);
        check_eq("auto_trig", auto_trig, 1);
        check_eq("auto_model", m_trig, 100 + 4095);
        verify_buffer();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
